regfile_bypass_sb: RTL and testbench

//  Parametrised register file with write-to-read bypass and a per-register

---
 rtl/regfile_bypass_sb.sv | 115 +++++++++++
 tb/tb_regfile_bypass_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_sb.sv
// Register file with same-cycle write-to-read bypass and a pending-write scoreboard.
// Latency: reads are combinational; writes, scoreboard and err update on the next clk edge.
// Backpressure: none internally; readNRdy tells decode when an operand is not yet valid so it can stall.
module regfile_bypass_sb #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int SEL_W   = 3,
    parameter int R0_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] read1RegSel,
    input  logic [SEL_W-1:0] read2RegSel,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             read1Rdy,
    output logic             read2Rdy,
    input  logic             issueEn,
    input  logic [SEL_W-1:0] issueRegSel,
    input  logic             writeEn,
    input  logic [SEL_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    output logic [NREGS-1:0] pendingVec,
    output logic             err
);

    localparam bit R0EN = (R0_ZERO != 0);

    logic [WIDTH-1:0] regs [NREGS];

    logic issueAct;
    logic writeAct;
    logic sameReg;
    logic doubleAlloc;
    logic orphanWb;
    logic hit1;
    logic hit2;
    logic isZero1;
    logic isZero2;

    // Qualify issue/write (reg 0 is inert when hardwired) and detect protocol violations.
    always_comb begin
        issueAct    = issueEn & ~(R0EN & (issueRegSel == '0));
        writeAct    = writeEn & ~(R0EN & (writeRegSel == '0));
        sameReg     = (issueRegSel == writeRegSel);
        // A same-cycle write to the issued reg retires the old allocation, so it is not a double.
        doubleAlloc = issueAct & pendingVec[issueRegSel] & ~(writeAct & sameReg);
        // A same-cycle issue to the written reg makes the writeback legitimate.
        orphanWb    = writeAct & ~pendingVec[writeRegSel] & ~(issueAct & sameReg);
    end

    // Read ports: stored value, overridden by the in-flight writeback, then by hardwired zero.
    always_comb begin
        hit1    = writeEn & (writeRegSel == read1RegSel);
        hit2    = writeEn & (writeRegSel == read2RegSel);
        isZero1 = R0EN & (read1RegSel == '0);
        isZero2 = R0EN & (read2RegSel == '0);

        read1Data = regs[read1RegSel];
        if (hit1) begin
            read1Data = writeData;
        end
        if (isZero1) begin
            read1Data = '0;
        end

        read2Data = regs[read2RegSel];
        if (hit2) begin
            read2Data = writeData;
        end
        if (isZero2) begin
            read2Data = '0;
        end

        // A same-cycle issue is deliberately not seen here; it shows up via pendingVec next cycle.
        read1Rdy = ~pendingVec[read1RegSel] | hit1 | isZero1;
        read2Rdy = ~pendingVec[read2RegSel] | hit2 | isZero2;
    end

    // Register storage: cleared on reset, written by writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeAct) begin
            regs[writeRegSel] <= writeData;
        end
    end

    // Scoreboard: issue sets, writeback clears, issue wins when both target the same reg.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pendingVec <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (issueAct && (issueRegSel == SEL_W'(i))) begin
                    pendingVec[i] <= 1'b1;
                end else if (writeAct && (writeRegSel == SEL_W'(i))) begin
                    pendingVec[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error flag; the offending operation still takes effect above.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (doubleAlloc || orphanWb) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: default config plus a 16x32 config with reg 0 hardwired.
// Latency: one step per clock; inputs driven on the falling edge, outputs checked 1ns later.
// Backpressure: none; the reference model tracks registers, pending bits and err as plain arrays.
module tb_regfile_bypass_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Configuration A: WIDTH 16, NREGS 8, R0_ZERO 0
    logic        aRst, aIss, aWr, aR1Rdy, aR2Rdy, aErr;
    logic [2:0]  aR1Sel, aR2Sel, aIssSel, aWrSel;
    logic [15:0] aWrDat, aR1Data, aR2Data;
    logic [7:0]  aPend;

    // Configuration B: WIDTH 32, NREGS 16, R0_ZERO 1
    logic        bRst, bIss, bWr, bR1Rdy, bR2Rdy, bErr;
    logic [3:0]  bR1Sel, bR2Sel, bIssSel, bWrSel;
    logic [31:0] bWrDat, bR1Data, bR2Data;
    logic [15:0] bPend;

    regfile_bypass_sb #(.WIDTH(16), .NREGS(8), .SEL_W(3), .R0_ZERO(0)) dutA (
        .clk(clk), .rst(aRst),
        .read1RegSel(aR1Sel), .read2RegSel(aR2Sel),
        .read1Data(aR1Data), .read2Data(aR2Data),
        .read1Rdy(aR1Rdy), .read2Rdy(aR2Rdy),
        .issueEn(aIss), .issueRegSel(aIssSel),
        .writeEn(aWr), .writeRegSel(aWrSel), .writeData(aWrDat),
        .pendingVec(aPend), .err(aErr)
    );

    regfile_bypass_sb #(.WIDTH(32), .NREGS(16), .SEL_W(4), .R0_ZERO(1)) dutB (
        .clk(clk), .rst(bRst),
        .read1RegSel(bR1Sel), .read2RegSel(bR2Sel),
        .read1Data(bR1Data), .read2Data(bR2Data),
        .read1Rdy(bR1Rdy), .read2Rdy(bR2Rdy),
        .issueEn(bIss), .issueRegSel(bIssSel),
        .writeEn(bWr), .writeRegSel(bWrSel), .writeData(bWrDat),
        .pendingVec(bPend), .err(bErr)
    );

    // Reference model, indexed by configuration (0 = A, 1 = B)
    logic [31:0] mReg  [2][16];
    bit          mPend [2][16];
    bit          mErr  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expData(input int d, input int r, input bit wr,
                                            input int wrSel, input logic [31:0] wdat);
        if (d == 1 && r == 0) return 32'h0;
        if (wr && wrSel == r) return wdat;
        return mReg[d][r];
    endfunction

    function automatic bit expRdy(input int d, input int r, input bit wr, input int wrSel);
        if (d == 1 && r == 0) return 1'b1;
        return !mPend[d][r] || (wr && wrSel == r);
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                mReg[d][i]  = 32'h0;
                mPend[d][i] = 1'b0;
            end
            mErr[d] = 1'b0;
        end
    endtask

    task automatic idleAll();
        aRst = 1'b1; aIss = 1'b0; aWr = 1'b0; aIssSel = '0; aWrSel = '0; aWrDat = '0;
        aR1Sel = '0; aR2Sel = '0;
        bRst = 1'b1; bIss = 1'b0; bWr = 1'b0; bIssSel = '0; bWrSel = '0; bWrDat = '0;
        bR1Sel = '0; bR2Sel = '0;
    endtask

    // One clock of stimulus on configuration d: drive, check against the model, clock, update model.
    task automatic step(input int d, input bit rstv, input bit iss, input int issSel,
                        input bit wr, input int wrSel, input logic [31:0] wdatIn,
                        input int r1, input int r2, input string tag);
        int          nr;
        bit          r0z, ei, ew;
        logic [31:0] wdat;
        logic [31:0] oD1, oD2;
        logic [15:0] eP, oP;
        logic        oR1, oR2, oE;

        nr   = (d == 1) ? 16 : 8;
        r0z  = (d == 1);
        wdat = (d == 1) ? wdatIn : {16'h0, wdatIn[15:0]};

        idleAll();
        if (d == 0) begin
            aRst = rstv; aIss = iss; aIssSel = 3'(issSel); aWr = wr; aWrSel = 3'(wrSel);
            aWrDat = wdat[15:0]; aR1Sel = 3'(r1); aR2Sel = 3'(r2);
        end else begin
            bRst = rstv; bIss = iss; bIssSel = 4'(issSel); bWr = wr; bWrSel = 4'(wrSel);
            bWrDat = wdat; bR1Sel = 4'(r1); bR2Sel = 4'(r2);
        end
        #1;

        eP = '0;
        for (int i = 0; i < nr; i++) eP[i] = mPend[d][i];
        oD1 = (d == 1) ? bR1Data : {16'h0, aR1Data};
        oD2 = (d == 1) ? bR2Data : {16'h0, aR2Data};
        oR1 = (d == 1) ? bR1Rdy : aR1Rdy;
        oR2 = (d == 1) ? bR2Rdy : aR2Rdy;
        oP  = (d == 1) ? bPend : {8'h0, aPend};
        oE  = (d == 1) ? bErr : aErr;

        chk({tag, "/read1Data"}, oD1, expData(d, r1, wr, wrSel, wdat));
        chk({tag, "/read2Data"}, oD2, expData(d, r2, wr, wrSel, wdat));
        chk({tag, "/read1Rdy"}, {31'h0, oR1}, {31'h0, expRdy(d, r1, wr, wrSel)});
        chk({tag, "/read2Rdy"}, {31'h0, oR2}, {31'h0, expRdy(d, r2, wr, wrSel)});
        chk({tag, "/pendingVec"}, {16'h0, oP}, {16'h0, eP});
        chk({tag, "/err"}, {31'h0, oE}, {31'h0, mErr[d]});

        @(posedge clk);
        if (!rstv) begin
            for (int i = 0; i < 16; i++) begin
                mReg[d][i]  = 32'h0;
                mPend[d][i] = 1'b0;
            end
            mErr[d] = 1'b0;
        end else begin
            ei = iss && !(r0z && issSel == 0);
            ew = wr && !(r0z && wrSel == 0);
            if (ei && mPend[d][issSel] && !(ew && wrSel == issSel)) mErr[d] = 1'b1;
            if (ew && !mPend[d][wrSel] && !(ei && wrSel == issSel)) mErr[d] = 1'b1;
            if (ew) begin
                mReg[d][wrSel]  = wdat;
                mPend[d][wrSel] = 1'b0;
            end
            if (ei) mPend[d][issSel] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        bit rs, iss, wr;
        int is, ws;

        modelReset();
        idleAll();
        aRst = 1'b0;
        bRst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idleAll();

        // Reset state: every register reads 0 and is ready
        for (int r = 0; r < 8; r++) step(0, 1, 0, 0, 0, 0, 32'h0, r, 7 - r, "t1_resetA");
        for (int r = 0; r < 16; r++) step(1, 1, 0, 0, 0, 0, 32'h0, r, 15 - r, "t1_resetB");
        chk("t1_err", {31'h0, aErr}, 32'h0);

        // Issue r3, see it stall, write it with bypass, then see it retire
        step(0, 1, 1, 3, 0, 0, 32'h0, 3, 3, "t2_issue");
        step(0, 1, 0, 0, 0, 0, 32'h0, 3, 3, "t2_pend");
        chk("t2_rdy0", {31'h0, aR1Rdy}, 32'h0);
        step(0, 1, 0, 0, 1, 3, 32'hBEEF, 3, 3, "t2_write");
        chk("t2_pend3", {31'h0, aPend[3]}, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 3, 0, "t2_read");
        chk("t2_data", {16'h0, aR1Data}, 32'h0000_BEEF);

        // Issue and write to an already pending reg in the same cycle
        step(0, 1, 1, 5, 0, 0, 32'h0, 5, 5, "t3_issue");
        step(0, 1, 1, 5, 1, 5, 32'h0042, 5, 0, "t3_both");
        chk("t3_pend5", {31'h0, aPend[5]}, 32'h1);
        chk("t3_err", {31'h0, aErr}, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 5, 5, "t3_read");
        chk("t3_data", {16'h0, aR1Data}, 32'h0000_0042);
        step(0, 1, 0, 0, 1, 5, 32'h0077, 5, 1, "t3_retire");

        // Double allocation raises a sticky err that only reset clears
        step(0, 1, 1, 2, 0, 0, 32'h0, 2, 0, "t4_issue1");
        step(0, 1, 1, 2, 0, 0, 32'h0, 2, 0, "t4_issue2");
        chk("t4_err_set", {31'h0, aErr}, 32'h1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 32'h0, k, 2, "t4_hold");
        chk("t4_err_sticky", {31'h0, aErr}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 32'h0, 2, 2, "t4_reset");
        chk("t4_err_clear", {31'h0, aErr}, 32'h0);

        // Hardwired reg 0 and wide top register on configuration B
        step(1, 1, 1, 0, 1, 0, 32'hFFFF, 0, 0, "t5_r0");
        chk("t5_r0_err", {31'h0, bErr}, 32'h0);
        chk("t5_r0_pend", {16'h0, bPend}, 32'h0);
        step(1, 1, 1, 15, 0, 0, 32'h0, 15, 0, "t5_issue15");
        step(1, 1, 0, 0, 1, 15, 32'hDEADBEEF, 15, 15, "t5_write15");
        step(1, 1, 0, 0, 0, 0, 32'h0, 15, 0, "t5_read15");
        chk("t5_data15", bR1Data, 32'hDEADBEEF);
        chk("t5_r0_data", bR2Data, 32'h0);

        // Reset beats a same-cycle write and issue
        step(0, 1, 1, 1, 0, 0, 32'h0, 1, 1, "t6_issue");
        step(0, 0, 1, 4, 1, 1, 32'h1234, 1, 1, "t6_rstwrite");
        step(0, 1, 0, 0, 0, 0, 32'h0, 1, 4, "t6_read");
        chk("t6_data", {16'h0, aR1Data}, 32'h0);
        chk("t6_pend", {24'h0, aPend}, 32'h0);
        chk("t6_err", {31'h0, aErr}, 32'h0);

        // Randomized traffic, mostly protocol-legal with occasional violations and resets
        for (int d = 0; d < 2; d++) begin
            nr = (d == 1) ? 16 : 8;
            for (int k = 0; k < 300; k++) begin
                rs  = ($urandom_range(0, 59) != 0);
                iss = ($urandom_range(0, 1) == 1);
                is  = int'($urandom_range(0, nr - 1));
                if (iss && mPend[d][is] && $urandom_range(0, 9) != 0) iss = 1'b0;
                wr  = ($urandom_range(0, 2) != 0);
                ws  = int'($urandom_range(0, nr - 1));
                if (wr && !mPend[d][ws] && $urandom_range(0, 9) != 0) wr = 1'b0;
                step(d, rs, iss, is, wr, ws, $urandom,
                     int'($urandom_range(0, nr - 1)), int'($urandom_range(0, nr - 1)),
                     (d == 1) ? "rndB" : "rndA");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
